memory_access_stage: RTL

- Pipeline stage directly downstream of the execute stage.
- Registers execute results and performs load/store to the data memory port via a valid/ready request and response handshake.
- Stalls the upstream stage while an access is in flight.
- Delivers one registered result per instruction to write-back.

---
 rtl/memory_access_stage_pkg.sv | 39 +++
 rtl/memory_access_stage_mem_data_align.sv | 67 ++++++
 rtl/memory_access_stage.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/memory_access_stage_pkg.sv
// Shared types for memory_access_stage: access size, FSM states and the
// instruction fields captured from the execute stage.
package memory_access_stage_pkg;

  localparam int unsigned INSN_WIDTH = 32;

  typedef enum logic [1:0] {
    BYTE = 2'd0,
    HALF = 2'd1,
    WORD = 2'd2
  } mem_access_size_e;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    REQ       = 2'd1,
    WAIT_RESP = 2'd2,
    DRAIN     = 2'd3
  } mem_stage_state_e;

  typedef struct packed {
    logic [INSN_WIDTH-1:0] pc;
    logic [INSN_WIDTH-1:0] insn;
    logic                  mem_read;
    logic                  mem_write;
    mem_access_size_e      size;
    logic                  load_unsigned;
    logic                  trap;
  } captured_insn_t;

  // Number of valid data bits for an access; the unused encoding behaves as a word.
  function automatic int unsigned size_bits(input mem_access_size_e size);
    case (size)
      BYTE:    return 8;
      HALF:    return 16;
      default: return 32;
    endcase
  endfunction

endpackage

// File: rtl/memory_access_stage_mem_data_align.sv
// mem_data_align: purely combinational lane steering for the data memory port:
// store byte enables and replicated write data, load extract/extend, misalign detect.
module mem_data_align
  import memory_access_stage_pkg::*;
#(
  parameter  int unsigned DATA_WIDTH = 32,
  localparam int unsigned BE_WIDTH   = DATA_WIDTH / 8,
  localparam int unsigned OFF_WIDTH  = $clog2(BE_WIDTH)
) (
  input  mem_access_size_e      size,
  input  logic                  load_unsigned,
  input  logic [OFF_WIDTH-1:0]  offset,
  input  logic [DATA_WIDTH-1:0] store_data,
  input  logic [DATA_WIDTH-1:0] rdata,
  output logic [BE_WIDTH-1:0]   byte_en,
  output logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] load_value,
  output logic                  misaligned
);

  logic [BE_WIDTH-1:0]   be_base;
  logic [DATA_WIDTH-1:0] shifted;
  logic [DATA_WIDTH-1:0] ext_mask;
  logic                  sign_bit;

  always_comb begin
    be_base = '0;
    wdata   = '0;
    case (size)
      BYTE: begin
        be_base = BE_WIDTH'(1);
        wdata   = {BE_WIDTH{store_data[7:0]}};
      end
      HALF: begin
        be_base = BE_WIDTH'(3);
        wdata   = {(BE_WIDTH / 2){store_data[15:0]}};
      end
      default: begin
        be_base = BE_WIDTH'(15);
        wdata   = {(BE_WIDTH / 4){store_data[31:0]}};
      end
    endcase
    byte_en = be_base << offset;
  end

  always_comb begin
    case (size)
      BYTE:    misaligned = 1'b0;
      HALF:    misaligned = offset[0];
      default: misaligned = |offset[1:0];
    endcase
  end

  // The addressed lane is brought down to bit 0, then everything above the
  // access width is replaced by the sign bit or zeros.
  always_comb begin
    shifted  = rdata >> {offset, 3'b000};
    ext_mask = ~((DATA_WIDTH'(1) << size_bits(size)) - DATA_WIDTH'(1));
    case (size)
      BYTE:    sign_bit = ~load_unsigned & shifted[7];
      HALF:    sign_bit = ~load_unsigned & shifted[15];
      default: sign_bit = ~load_unsigned & shifted[31];
    endcase
    load_value = sign_bit ? (shifted | ext_mask) : (shifted & ~ext_mask);
  end

endmodule

// File: rtl/memory_access_stage.sv
// memory_access_stage: registers execute results and runs loads/stores over a
// valid/ready data memory port. Optional stall counter: MEMORY_ACCESS_STAGE_STALL_COUNTER_EN.
module memory_access_stage
  import memory_access_stage_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    ex_valid,
  input  logic [31:0]             ex_pc,
  input  logic [31:0]             ex_insn,
  input  logic                    ex_mem_read,
  input  logic                    ex_mem_write,
  input  logic [1:0]              ex_mem_size,
  input  logic                    ex_load_unsigned,
  input  logic [DATA_WIDTH-1:0]   ex_dst_value,
  input  logic [DATA_WIDTH-1:0]   ex_store_data,
  input  logic                    ex_trap,
  input  logic                    flush,
  output logic                    stall_out,
  output logic                    dmem_req_valid,
  input  logic                    dmem_req_ready,
  output logic                    dmem_req_write,
  output logic [ADDR_WIDTH-1:0]   dmem_req_addr,
  output logic [DATA_WIDTH/8-1:0] dmem_req_byte_en,
  output logic [DATA_WIDTH-1:0]   dmem_req_wdata,
  input  logic                    dmem_resp_valid,
  input  logic [DATA_WIDTH-1:0]   dmem_resp_rdata,
  output logic                    ma_valid,
  output logic [31:0]             ma_pc,
  output logic [31:0]             ma_insn,
  output logic [DATA_WIDTH-1:0]   ma_dst_value,
  output logic                    ma_misaligned,
  output logic                    ma_trap
`ifdef MEMORY_ACCESS_STAGE_STALL_COUNTER_EN
  ,
  output logic [31:0]             perf_stall_cycles
`endif
);

  localparam int unsigned BE_WIDTH  = DATA_WIDTH / 8;
  localparam int unsigned OFF_WIDTH = $clog2(BE_WIDTH);

  mem_stage_state_e state, state_next;

  captured_insn_t        cap, ex_cap;
  logic [DATA_WIDTH-1:0] cap_dst;
  logic [DATA_WIDTH-1:0] cap_store_data;
  logic                  capture;
  logic                  ex_is_mem;

  mem_access_size_e      al_size;
  logic [OFF_WIDTH-1:0]  al_offset;
  logic [BE_WIDTH-1:0]   al_byte_en;
  logic [DATA_WIDTH-1:0] al_wdata;
  logic [DATA_WIDTH-1:0] al_load_value;
  logic                  al_misaligned;

  logic                  res_valid;
  logic [31:0]           res_pc;
  logic [31:0]           res_insn;
  logic [DATA_WIDTH-1:0] res_dst;
  logic                  res_misaligned;
  logic                  res_trap;

  always_comb begin
    ex_cap.pc            = ex_pc;
    ex_cap.insn          = ex_insn;
    ex_cap.mem_read      = ex_mem_read;
    ex_cap.mem_write     = ex_mem_write;
    ex_cap.size          = mem_access_size_e'(ex_mem_size);
    ex_cap.load_unsigned = ex_load_unsigned;
    ex_cap.trap          = ex_trap;
  end

  assign ex_is_mem = ex_mem_read | ex_mem_write;

  // One aligner serves both jobs: in IDLE it judges the incoming address,
  // otherwise it steers lanes for the captured access.
  always_comb begin
    if (state == IDLE) begin
      al_size   = ex_cap.size;
      al_offset = ex_dst_value[OFF_WIDTH-1:0];
    end else begin
      al_size   = cap.size;
      al_offset = cap_dst[OFF_WIDTH-1:0];
    end
  end

  mem_data_align #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_align (
    .size          (al_size),
    .load_unsigned (cap.load_unsigned),
    .offset        (al_offset),
    .store_data    (cap_store_data),
    .rdata         (dmem_resp_rdata),
    .byte_en       (al_byte_en),
    .wdata         (al_wdata),
    .load_value    (al_load_value),
    .misaligned    (al_misaligned)
  );

  assign stall_out        = (state != IDLE);
  assign dmem_req_valid   = (state == REQ);
  assign dmem_req_write   = dmem_req_valid & cap.mem_write;
  assign dmem_req_addr    = dmem_req_valid ?
                            {cap_dst[ADDR_WIDTH-1:OFF_WIDTH], {OFF_WIDTH{1'b0}}} : '0;
  assign dmem_req_byte_en = dmem_req_valid ? al_byte_en : '0;
  assign dmem_req_wdata   = dmem_req_write ? al_wdata : '0;

  always_comb begin
    // NOTE: every variable gets a default before the case so no path can infer a latch.
    state_next     = state;
    capture        = 1'b0;
    res_valid      = 1'b0;
    res_pc         = cap.pc;
    res_insn       = cap.insn;
    res_dst        = cap_dst;
    res_misaligned = 1'b0;
    res_trap       = 1'b0;
    case (state)
      IDLE: begin
        if (ex_valid && !flush) begin
          capture = 1'b1;
          if (ex_is_mem && !ex_trap && !al_misaligned) begin
            state_next = REQ;
          end else begin
            res_valid      = 1'b1;
            res_pc         = ex_pc;
            res_insn       = ex_insn;
            res_dst        = ex_dst_value;
            res_misaligned = ex_is_mem & al_misaligned;
            res_trap       = ex_trap | (ex_is_mem & al_misaligned);
          end
        end
      end
      REQ: begin
        if (flush) begin
          // An accepted load still owes a response; an accepted store is simply done.
          state_next = (dmem_req_ready && !cap.mem_write) ? DRAIN : IDLE;
        end else if (dmem_req_ready) begin
          if (cap.mem_write) begin
            res_valid  = 1'b1;
            state_next = IDLE;
          end else begin
            state_next = WAIT_RESP;
          end
        end
      end
      WAIT_RESP: begin
        if (flush) begin
          state_next = dmem_resp_valid ? IDLE : DRAIN;
        end else if (dmem_resp_valid) begin
          res_valid  = 1'b1;
          res_dst    = al_load_value;
          state_next = IDLE;
        end
      end
      DRAIN: begin
        if (dmem_resp_valid) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: captured state is reset too, so every request field reads zero out of reset.
      state          <= IDLE;
      cap            <= '0;
      cap_dst        <= '0;
      cap_store_data <= '0;
      ma_valid       <= 1'b0;
      ma_pc          <= '0;
      ma_insn        <= '0;
      ma_dst_value   <= '0;
      ma_misaligned  <= 1'b0;
      ma_trap        <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state    <= state_next;
      ma_valid <= res_valid;
      if (capture) begin
        cap            <= ex_cap;
        cap_dst        <= ex_dst_value;
        cap_store_data <= ex_store_data;
      end
      if (res_valid) begin
        ma_pc         <= res_pc;
        ma_insn       <= res_insn;
        ma_dst_value  <= res_dst;
        ma_misaligned <= res_misaligned;
        ma_trap       <= res_trap;
      end
    end
  end

`ifdef MEMORY_ACCESS_STAGE_STALL_COUNTER_EN
  always_ff @(posedge clk) begin
    if (rst)            perf_stall_cycles <= '0;
    else if (stall_out) perf_stall_cycles <= perf_stall_cycles + 32'd1;
  end
`endif

endmodule
